// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: opcode/funct3 constants, memory-stage FSM states
// and the lane helpers used by the memory-access stage.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] be;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << lane;
            F3_H, F3_HU: be = 4'b0011 << {lane[1], 1'b0};
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = lane[0];
            F3_W:        mis = (lane != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] rs2);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{rs2[7:0]}};
            F3_H:    d = {2{rs2[15:0]}};
            default: d = rs2;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rv32i_loadAlign.sv
// Load data alignment: picks the byte/half lane named by the low address bits
// out of the bus word and sign- or zero-extends it to 32 bits.
module rv32i_loadAlign
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   value = {24'd0, byte_sel};
            F3_H:    value = {{16{half_sel[15]}}, half_sel};
            F3_HU:   value = {16'd0, half_sel};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/rv32i_memtop.sv
// rv32i memory-access stage: single-outstanding req/ack data bus with upstream
// stall, bus timeout, misalignment trap and registered writeback forwarding.
module rv32i_memtop
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  wb_reg_in,
    input  logic        wb_en_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] wb_data_out,
    output logic [31:0] iw_out,
    output logic [31:0] pc_out,
    output logic [4:0]  wb_reg_out,
    output logic        wb_en_out,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        df_mem_enable,
    output logic [4:0]  df_mem_reg,
    output logic [31:0] df_mem_data
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t       state;
    logic [CNT_W-1:0] wait_cnt;

    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_iw;
    logic [31:0] req_pc;
    logic [3:0]  req_be;
    logic [2:0]  req_f3;
    logic [4:0]  req_wb_reg;
    logic        req_we;
    logic        req_wb_en;

    logic [2:0]  f3;
    logic        is_load;
    logic        is_store;
    logic        mem_op;
    logic        misaligned;
    logic [31:0] load_value;

    assign f3         = iw_in[14:12];
    assign is_load    = (iw_in[6:0] == OPC_LOAD);
    assign is_store   = (iw_in[6:0] == OPC_STORE);
    assign mem_op     = (is_load && (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) ||
                        (is_store && (f3 inside {F3_B, F3_H, F3_W}));
    assign misaligned = mem_op && is_misaligned(f3, alu_in[1:0]);

    // Bus side is driven purely from state and request registers.
    assign stall     = (state == BUSY);
    assign mem_req   = stall;
    assign mem_we    = stall && req_we;
    assign mem_addr  = stall ? {req_addr[31:2], 2'b00} : 32'd0;
    assign mem_be    = stall ? req_be : 4'd0;
    assign mem_wdata = stall ? req_wdata : 32'd0;

    assign df_mem_enable = wb_en_out;
    assign df_mem_reg    = wb_reg_out;
    assign df_mem_data   = wb_data_out;

    rv32i_loadAlign u_load_align (
        .rdata  (mem_rdata),
        .lane   (req_addr[1:0]),
        .funct3 (req_f3),
        .value  (load_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_iw       <= '0;
            req_pc       <= '0;
            req_be       <= '0;
            req_f3       <= '0;
            req_wb_reg   <= '0;
            req_we       <= 1'b0;
            req_wb_en    <= 1'b0;
            wb_data_out  <= '0;
            iw_out       <= '0;
            pc_out       <= '0;
            wb_reg_out   <= '0;
            wb_en_out    <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op && !misaligned) begin
                        state      <= BUSY;
                        wait_cnt   <= '0;
                        req_addr   <= alu_in;
                        req_wdata  <= store_data(f3, rs2_data_in);
                        req_be     <= byte_enables(f3, alu_in[1:0]);
                        req_we     <= is_store;
                        req_f3     <= f3;
                        req_iw     <= iw_in;
                        req_pc     <= pc_in;
                        req_wb_reg <= wb_reg_in;
                        req_wb_en  <= wb_en_in;
                        // Bubble towards writeback while the access is in flight.
                        wb_data_out <= '0;
                        iw_out      <= '0;
                        pc_out      <= '0;
                        wb_reg_out  <= '0;
                        wb_en_out   <= 1'b0;
                    end else begin
                        wb_data_out  <= alu_in;
                        iw_out       <= iw_in;
                        pc_out       <= pc_in;
                        wb_reg_out   <= wb_reg_in;
                        wb_en_out    <= wb_en_in && !is_load && !is_store;
                        misalign_err <= misaligned;
                    end
                end
                BUSY: begin
                    if (mem_ack || (wait_cnt == CNT_LAST)) begin
                        state       <= IDLE;
                        iw_out      <= req_iw;
                        pc_out      <= req_pc;
                        wb_reg_out  <= req_wb_reg;
                        wb_data_out <= (mem_ack && !req_we) ? load_value : req_addr;
                        wb_en_out   <= mem_ack && !req_we && req_wb_en;
                        bus_err     <= !mem_ack;
                    end else begin
                        wait_cnt  <= wait_cnt + CNT_W'(1);
                        wb_en_out <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_memtop.sv
// Directed bench for rv32i_memtop: table-driven pass-through/misalign and
// memory-access vectors plus timeout and reset-during-access sequences.
module tb_rv32i_memtop;

    localparam int unsigned TIMEOUT = 4;
    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_in, iw_in, pc_in, rs2_data_in;
    logic [4:0]  wb_reg_in;
    logic        wb_en_in;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] wb_data_out, iw_out, pc_out;
    logic [4:0]  wb_reg_out;
    logic        wb_en_out, misalign_err, bus_err;
    logic        df_mem_enable;
    logic [4:0]  df_mem_reg;
    logic [31:0] df_mem_data;

    int checks = 0;
    int errors = 0;

    // Mem-side observations captured by run_access.
    int          busy_cycles;
    int          req_cycles;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we;

    rv32i_memtop #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .alu_in(alu_in), .iw_in(iw_in), .pc_in(pc_in),
        .rs2_data_in(rs2_data_in), .wb_reg_in(wb_reg_in), .wb_en_in(wb_en_in),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_data_out(wb_data_out), .iw_out(iw_out), .pc_out(pc_out),
        .wb_reg_out(wb_reg_out), .wb_en_out(wb_en_out), .misalign_err(misalign_err),
        .bus_err(bus_err), .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg),
        .df_mem_data(df_mem_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] alu;
        logic [31:0] iw;
        logic [4:0]  rg;
        logic        en;
        logic [31:0] exp_data;
        logic        exp_en;
        logic        exp_mis;
    } pass_vec_t;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] iw;
        logic [31:0] rs2;
        int          ack_at;
        logic [31:0] rdata;
        int          exp_busy;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_en;
    } acc_vec_t;

    pass_vec_t pass_tbl[10];
    acc_vec_t  acc_tbl[9];

    function automatic logic [31:0] mk_iw(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
        return {17'd0, f3, rd, opc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] iw, input logic [31:0] pc,
                         input logic [31:0] rs2, input logic [4:0] rg, input logic en);
        alu_in = alu; iw_in = iw; pc_in = pc; rs2_data_in = rs2; wb_reg_in = rg; wb_en_in = en;
    endtask

    task automatic drive_nop();
        drive(32'd0, mk_iw(OPC_OP, 3'b000, 5'd0), 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    // Issues one access and waits (bounded) for stall to drop; ack_at=0 never acks.
    task automatic run_access(input logic [31:0] alu, input logic [31:0] iw, input logic [31:0] pc,
                              input logic [31:0] rs2, input logic [4:0] rg, input logic en,
                              input int ack_at, input logic [31:0] rdata);
        drive(alu, iw, pc, rs2, rg, en);
        busy_cycles = 0;
        req_cycles  = 0;
        seen_addr = 'x; seen_wdata = 'x; seen_be = 'x; seen_we = 1'bx;
        @(posedge clk); #1;
        while (stall && busy_cycles < 50) begin
            busy_cycles++;
            if (mem_req) req_cycles++;
            if (busy_cycles == 1) begin
                seen_addr = mem_addr; seen_wdata = mem_wdata; seen_be = mem_be; seen_we = mem_we;
            end
            chk("busy wb_en_out", {31'd0, wb_en_out}, 32'd0);
            if (busy_cycles == ack_at) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = 32'hDEAD_0000;
        end
        if (busy_cycles >= 50) chk("access bound", 32'd1, 32'd0);
        drive_nop();
    endtask

    initial begin
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0;
        drive_nop();

        pass_tbl[0] = '{32'h0000_1234, mk_iw(OPC_OP,  3'b000, 5'd5), 5'd5, 1'b1, 32'h0000_1234, 1'b1, 1'b0};
        pass_tbl[1] = '{32'hDEAD_BEEF, mk_iw(OPC_OP,  3'b000, 5'd6), 5'd6, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};
        pass_tbl[2] = '{32'h0000_0101, mk_iw(OPC_LD,  3'b010, 5'd7), 5'd7, 1'b1, 32'h0000_0101, 1'b0, 1'b1};
        pass_tbl[3] = '{32'h0000_0103, mk_iw(OPC_LD,  3'b001, 5'd8), 5'd8, 1'b1, 32'h0000_0103, 1'b0, 1'b1};
        pass_tbl[4] = '{32'h0000_0102, mk_iw(OPC_ST,  3'b010, 5'd0), 5'd9, 1'b1, 32'h0000_0102, 1'b0, 1'b1};
        pass_tbl[5] = '{32'h0000_0201, mk_iw(OPC_ST,  3'b001, 5'd0), 5'd1, 1'b0, 32'h0000_0201, 1'b0, 1'b1};
        pass_tbl[6] = '{32'h0000_0001, mk_iw(OPC_LD,  3'b101, 5'd2), 5'd2, 1'b1, 32'h0000_0001, 1'b0, 1'b1};
        pass_tbl[7] = '{32'h0000_0100, mk_iw(OPC_LD,  3'b011, 5'd3), 5'd3, 1'b1, 32'h0000_0100, 1'b0, 1'b0};
        pass_tbl[8] = '{32'h0000_0104, mk_iw(OPC_ST,  3'b100, 5'd0), 5'd4, 1'b1, 32'h0000_0104, 1'b0, 1'b0};
        pass_tbl[9] = '{32'hABCD_E000, mk_iw(OPC_LUI, 3'b000, 5'd31), 5'd31, 1'b1, 32'hABCD_E000, 1'b1, 1'b0};

        acc_tbl[0] = '{32'h103, mk_iw(OPC_LD, 3'b000, 5'd7), 32'd0, 2, 32'h80FF_FF00, 2, 32'h100, 4'b1000, 1'b0, 32'd0, 32'hFFFF_FF80, 1'b1};
        acc_tbl[1] = '{32'h103, mk_iw(OPC_LD, 3'b100, 5'd7), 32'd0, 2, 32'h80FF_FF00, 2, 32'h100, 4'b1000, 1'b0, 32'd0, 32'h0000_0080, 1'b1};
        acc_tbl[2] = '{32'h102, mk_iw(OPC_ST, 3'b001, 5'd3), 32'hABCD_1234, 1, 32'd0, 1, 32'h100, 4'b1100, 1'b1, 32'h1234_1234, 32'h0000_0102, 1'b0};
        acc_tbl[3] = '{32'h102, mk_iw(OPC_LD, 3'b001, 5'd4), 32'd0, 1, 32'h8001_7FFF, 1, 32'h100, 4'b1100, 1'b0, 32'd0, 32'hFFFF_8001, 1'b1};
        acc_tbl[4] = '{32'h100, mk_iw(OPC_LD, 3'b101, 5'd4), 32'd0, 1, 32'h7FFF_8001, 1, 32'h100, 4'b0011, 1'b0, 32'd0, 32'h0000_8001, 1'b1};
        acc_tbl[5] = '{32'h104, mk_iw(OPC_LD, 3'b010, 5'd10), 32'd0, 3, 32'h1234_5678, 3, 32'h104, 4'b1111, 1'b0, 32'd0, 32'h1234_5678, 1'b1};
        acc_tbl[6] = '{32'h101, mk_iw(OPC_ST, 3'b000, 5'd0), 32'h0000_00A5, 1, 32'd0, 1, 32'h100, 4'b0010, 1'b1, 32'hA5A5_A5A5, 32'h0000_0101, 1'b0};
        acc_tbl[7] = '{32'h108, mk_iw(OPC_ST, 3'b010, 5'd0), 32'hCAFE_F00D, 4, 32'd0, 4, 32'h108, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h0000_0108, 1'b0};
        acc_tbl[8] = '{32'h102, mk_iw(OPC_LD, 3'b000, 5'd11), 32'd0, 1, 32'h007F_0000, 1, 32'h100, 4'b0100, 1'b0, 32'd0, 32'h0000_007F, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst wb_data_out", wb_data_out, 32'd0);
        chk("rst wb_en_out", {31'd0, wb_en_out}, 32'd0);
        chk("rst errs", {30'd0, misalign_err, bus_err}, 32'd0);
        chk("rst df_mem", {df_mem_data[30:0] | {26'd0, df_mem_reg}, df_mem_enable}, 32'd0);
        reset = 1'b0;

        // Single-cycle instructions: pass-through, misaligned, undefined funct3
        for (int i = 0; i < 10; i++) begin
            drive(pass_tbl[i].alu, pass_tbl[i].iw, 32'h1000 + 32'(i * 4), 32'h5555_5555,
                  pass_tbl[i].rg, pass_tbl[i].en);
            @(posedge clk); #1;
            chk($sformatf("pass%0d wb_data_out", i), wb_data_out, pass_tbl[i].exp_data);
            chk($sformatf("pass%0d df_mem_data", i), df_mem_data, pass_tbl[i].exp_data);
            chk($sformatf("pass%0d wb_en_out", i), {31'd0, wb_en_out}, {31'd0, pass_tbl[i].exp_en});
            chk($sformatf("pass%0d df_mem_enable", i), {31'd0, df_mem_enable}, {31'd0, pass_tbl[i].exp_en});
            chk($sformatf("pass%0d misalign_err", i), {31'd0, misalign_err}, {31'd0, pass_tbl[i].exp_mis});
            chk($sformatf("pass%0d wb_reg_out", i), {27'd0, wb_reg_out}, {27'd0, pass_tbl[i].rg});
            chk($sformatf("pass%0d df_mem_reg", i), {27'd0, df_mem_reg}, {27'd0, pass_tbl[i].rg});
            chk($sformatf("pass%0d iw_out", i), iw_out, pass_tbl[i].iw);
            chk($sformatf("pass%0d pc_out", i), pc_out, 32'h1000 + 32'(i * 4));
            chk($sformatf("pass%0d stall/req", i), {30'd0, stall, mem_req}, 32'd0);
        end

        // Memory accesses with acks at various BUSY cycles
        for (int i = 0; i < 9; i++) begin
            run_access(acc_tbl[i].alu, acc_tbl[i].iw, 32'h2000 + 32'(i * 4), acc_tbl[i].rs2,
                       acc_tbl[i].iw[11:7], 1'b1, acc_tbl[i].ack_at, acc_tbl[i].rdata);
            chk($sformatf("acc%0d stall cycles", i), 32'(busy_cycles), 32'(acc_tbl[i].exp_busy));
            chk($sformatf("acc%0d req cycles", i), 32'(req_cycles), 32'(acc_tbl[i].exp_busy));
            chk($sformatf("acc%0d mem_addr", i), seen_addr, acc_tbl[i].exp_addr);
            chk($sformatf("acc%0d mem_be", i), {28'd0, seen_be}, {28'd0, acc_tbl[i].exp_be});
            chk($sformatf("acc%0d mem_we", i), {31'd0, seen_we}, {31'd0, acc_tbl[i].exp_we});
            if (acc_tbl[i].exp_we)
                chk($sformatf("acc%0d mem_wdata", i), seen_wdata, acc_tbl[i].exp_wdata);
            chk($sformatf("acc%0d wb_data_out", i), wb_data_out, acc_tbl[i].exp_data);
            chk($sformatf("acc%0d df_mem_data", i), df_mem_data, acc_tbl[i].exp_data);
            chk($sformatf("acc%0d wb_en_out", i), {31'd0, wb_en_out}, {31'd0, acc_tbl[i].exp_en});
            chk($sformatf("acc%0d wb_reg_out", i), {27'd0, wb_reg_out}, {27'd0, acc_tbl[i].iw[11:7]});
            chk($sformatf("acc%0d pc_out", i), pc_out, 32'h2000 + 32'(i * 4));
            chk($sformatf("acc%0d bus_err", i), {31'd0, bus_err}, 32'd0);
        end

        // Timeout: no ack for a LW at 0x200
        run_access(32'h200, mk_iw(OPC_LD, 3'b010, 5'd12), 32'h3000, 32'd0, 5'd12, 1'b1, 0, 32'd0);
        chk("tmo stall cycles", 32'(busy_cycles), 32'(TIMEOUT));
        chk("tmo req cycles", 32'(req_cycles), 32'(TIMEOUT));
        chk("tmo bus_err", {31'd0, bus_err}, 32'd1);
        chk("tmo wb_en_out", {31'd0, wb_en_out}, 32'd0);
        chk("tmo stall after", {31'd0, stall}, 32'd0);
        drive(32'h0000_0777, mk_iw(OPC_OP, 3'b000, 5'd13), 32'h3004, 32'd0, 5'd13, 1'b1);
        @(posedge clk); #1;
        chk("tmo next bus_err", {31'd0, bus_err}, 32'd0);
        chk("tmo next wb_data_out", wb_data_out, 32'h0000_0777);
        chk("tmo next wb_en_out", {31'd0, wb_en_out}, 32'd1);
        chk("tmo next stall", {31'd0, stall}, 32'd0);

        // Reset in the 2nd BUSY cycle, then a stray ack while IDLE
        drive(32'h300, mk_iw(OPC_LD, 3'b010, 5'd14), 32'h4000, 32'd0, 5'd14, 1'b1);
        @(posedge clk); #1;
        chk("rb busy1 stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("rb busy2 req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive_nop();
        chk("rb mem_req", {31'd0, mem_req}, 32'd0);
        chk("rb stall", {31'd0, stall}, 32'd0);
        chk("rb mem_addr", mem_addr, 32'd0);
        chk("rb mem_be", {28'd0, mem_be}, 32'd0);
        chk("rb wb_data_out", wb_data_out, 32'd0);
        chk("rb iw/pc", iw_out | pc_out, 32'd0);
        chk("rb wb_reg/en", {26'd0, wb_reg_out, wb_en_out}, 32'd0);
        chk("rb errs", {30'd0, misalign_err, bus_err}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("late ack mem_req", {31'd0, mem_req}, 32'd0);
        chk("late ack wb_en_out", {31'd0, wb_en_out}, 32'd0);
        chk("late ack wb_data_out", wb_data_out, 32'd0);
        chk("late ack bus_err", {31'd0, bus_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_memtop.md
# rv32i_memTop

Memory-access stage of the rv32i pipeline. Sits between the execute stage and writeback. It consumes the execute-stage pipeline register (ALU result, instruction word, PC, writeback register and enable). It performs loads and stores over a single-outstanding request/acknowledge data-memory bus, stalling upstream while a request is in flight. It forwards its registered writeback result to the decode stage.

## Interface
- TIMEOUT, 255: bus-wait cycles allowed before a request is abandoned (≥1).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset; one clock.
- alu_in  in  32  execute-stage ALU result; effective address for loads and stores.
- iw_in  in  32  instruction word.
- pc_in  in  32  program counter.
- rs2_data_in  in  32  store data, registered alongside the execute outputs.
- wb_reg_in  in  5  destination register.
- wb_en_in  in  1  writeback enable.
- stall  out  1  high while an access is in flight; upstream holds all inputs.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word address, {addr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data, valid when mem_ack is high.
- mem_ack  in  1  completes the current request.
- wb_data_out  out  32  result to writeback.
- iw_out, pc_out  out  32  registered pass-through.
- wb_reg_out  out  5  registered pass-through.
- wb_en_out  out  1  qualified writeback enable.
- misalign_err  out  1  one-cycle pulse.
- bus_err  out  1  one-cycle pulse.
- df_mem_enable  out  1  forwarded enable; equals wb_en_out.
- df_mem_reg  out  5  forwarded register; equals wb_reg_out.
- df_mem_data  out  32  forwarded data; equals wb_data_out.

## Operation
- Instruction classes (opcode = iw[6:0]):
  - Load: 0000011.
  - Store: 0100011.
  - Anything else passes through.
- Address: addr = alu_in. Funct3 = iw[14:12].
- Accept: inputs are sampled on every rising edge where state is IDLE and reset is low.
- Pass-through instructions:
  - wb_data_out ← alu_in.
  - wb_en_out ← wb_en_in.
  - Other outputs copied.
- Misalignment:
  - Condition: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - Result: no bus access, misalign_err=1 for one cycle, wb_en_out=0, state stays IDLE.
- Aligned load or store:
  - Capture address, byte enables, write data, funct3, iw, pc and wb_reg into request registers.
  - Go to BUSY.
- State machine (states IDLE and BUSY):
  - BUSY drives mem_req=1 and stall=1 from the request registers.
  - During BUSY, outputs present a bubble with wb_en_out=0.
  - In BUSY with mem_ack=1: the result registers at that edge and the state returns to IDLE.
  - A new input is accepted only on the following edge.
- Byte enables:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<{addr[1],1'b0}.
  - SW: 4'b1111.
  - Loads drive the same pattern; mem_we=0.
- Store data:
  - SB: {4{rs2[7:0]}}.
  - SH: {2{rs2[15:0]}}.
  - SW: rs2.
- Store completion: wb_en_out=0, wb_data_out=addr.
- Load extract uses the lane selected by addr[1:0]:
  - LB/LBU: byte, sign- or zero-extended to 32.
  - LH/LHU: half at addr[1], sign- or zero-extended.
  - LW: full word.
  - wb_en_out ← captured wb_en.
- Undefined funct3 under the load or store opcode: treated as pass-through, no access, wb_en_out=0.
- Timeout:
  - Wait counter clears on entry to BUSY and increments on each BUSY cycle without ack.
  - At count TIMEOUT-1 with no ack: IDLE next edge, bus_err=1 for one cycle, wb_en_out=0.
  - mem_req is therefore high for exactly TIMEOUT cycles.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - mem_req, mem_we, mem_be and mem_addr are 0.
  - Every registered output is 0, including both error pulses and all df_mem_*.
- Reset asserted during BUSY abandons the request. mem_req is low from the cycle after the reset edge. No result and no error are produced.
- Pass-through and misaligned instructions: 1-cycle latency.
- Memory access with ack in BUSY cycle k (k≥1): result registers at the end of cycle k. stall is high for k cycles.
- stall and mem_* are decoded from state and request registers only. They have no combinational path from any input.
- mem_ack while IDLE is ignored.

## Structure
- Shared package rv32i_pkg holds:
  - Opcode constants OPC_LOAD and OPC_STORE.
  - Funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - The mem_state_t enum {IDLE, BUSY}.
- One sub-module, rv32i_loadAlign: combinational (rdata, addr[1:0], funct3) → extended 32-bit value.

## Test plan
- Pass-through: alu_in=0x00001234, wb_reg=5, wb_en=1, ADD iw → next cycle wb_data_out=df_mem_data=0x00001234, wb_reg_out=5, wb_en_out=1; stall never high.
- LB at 0x00000103, ack on the 2nd BUSY cycle with rdata=0x80FFFF00 → mem_addr=0x100, mem_be=4'b1000, stall high 2 cycles, wb_data_out=0xFFFFFF80. The same case with LBU gives 0x00000080.
- SH at 0x00000102, rs2=0xABCD1234, immediate ack → mem_we=1, mem_be=4'b1100, mem_wdata=0x12341234, wb_en_out=0.
- LW at 0x00000101 → misalign_err pulses 1 cycle, mem_req never asserts, wb_en_out=0.
- TIMEOUT=4, LW at 0x200, no ack → mem_req high exactly 4 cycles, bus_err pulses once, stall low afterwards, and the next held instruction is accepted.
- Reset asserted in the 2nd BUSY cycle → mem_req=0 and all outputs 0 from the following cycle; a late ack is ignored.
